fetch_ctrl: RTL and testbench

- Sequences instruction fetch against a handshake-based instruction memory (req/gnt address phase, rvalid data phase).
- Replaces the fixed one-cycle fetch assumption: owns the fetch PC, keeps at most one request outstanding, holds the fetched instruction while decode stalls, and handles redirects (branch/jal/jalr) at any point, discarding stale responses.
- Sits between the memory port and decode; redirect inputs come from execute (pcsrc/pctarget).

---
 rtl/fetch_ctrl_if.sv | 14 +
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port: req/gnt address phase, rvalid/rdata response phase.
interface fetch_ctrl_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                gnt;
  logic                rvalid;
  logic [XLEN-1:0]     rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one memory request in flight, holds the
// fetched instruction across decode stalls and squashes responses made stale by redirects.
module fetch_ctrl #(
  parameter int unsigned         XLEN     = 32,
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                stall_i,
  fetch_ctrl_if.master        mem,
  output logic                inst_valid_o,
  output logic [XLEN-1:0]     inst_o,
  output logic [PC_WIDTH-1:0] inst_pc_o,
  output logic [PC_WIDTH-1:0] pcplus4_o
);

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [PC_WIDTH-1:0] pc_q, pc_n;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_n;
  logic                redir_pend_q, redir_pend_n;
  logic                discard_q, discard_n;
  logic                req_q;
  logic                inst_valid_n;
  logic [XLEN-1:0]     inst_n;
  logic [PC_WIDTH-1:0] inst_pc_n;
  logic [PC_WIDTH-1:0] target;
  logic                consume;

  assign target  = redirect_pc_i & ALIGN_MASK;
  assign consume = inst_valid_o & ~stall_i;

  assign mem.req  = req_q;
  assign mem.addr = pc_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      redir_pend_q <= 1'b0;
      discard_q    <= 1'b0;
      req_q        <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      pcplus4_o    <= PC_STEP;
    end else begin
      state_q      <= state_n;
      pc_q         <= pc_n;
      pend_pc_q    <= pend_pc_n;
      redir_pend_q <= redir_pend_n;
      discard_q    <= discard_n;
      req_q        <= (state_n == ST_REQ);
      inst_valid_o <= inst_valid_n;
      inst_o       <= inst_n;
      inst_pc_o    <= inst_pc_n;
      pcplus4_o    <= inst_pc_n + PC_STEP;
    end
  end

  // Next-state: a redirect always outranks rvalid and consume
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: state_n = ST_REQ;
      ST_REQ:  if (mem.gnt) state_n = ST_WAIT;
      ST_WAIT: begin
        if (redirect_i) begin
          if (mem.rvalid) state_n = ST_REQ;
        end else if (mem.rvalid) begin
          state_n = discard_q ? ST_REQ : ST_HOLD;
        end
      end
      ST_HOLD: if (redirect_i || consume) state_n = ST_REQ;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath updates; the address stays frozen until gnt, so REQ-phase redirects are parked
  always_comb begin
    pc_n         = pc_q;
    pend_pc_n    = pend_pc_q;
    redir_pend_n = redir_pend_q;
    discard_n    = discard_q;
    inst_valid_n = inst_valid_o;
    inst_n       = inst_o;
    inst_pc_n    = inst_pc_o;
    case (state_q)
      ST_IDLE: if (redirect_i) pc_n = target;
      ST_REQ: begin
        if (mem.gnt) begin
          redir_pend_n = 1'b0;
          if (redirect_i) begin
            pc_n      = target;
            discard_n = 1'b1;
          end else if (redir_pend_q) begin
            pc_n      = pend_pc_q;
            discard_n = 1'b1;
          end
        end else if (redirect_i) begin
          pend_pc_n    = target;
          redir_pend_n = 1'b1;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          pc_n      = target;
          discard_n = ~mem.rvalid;
        end else if (mem.rvalid) begin
          if (discard_q) begin
            discard_n = 1'b0;
          end else begin
            inst_n       = mem.rdata;
            inst_pc_n    = pc_q;
            inst_valid_n = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_n         = target;
          inst_valid_n = 1'b0;
        end else if (consume) begin
          pc_n         = pc_q + PC_STEP;
          inst_valid_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pcplus4;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl_if #(.XLEN(32), .PC_WIDTH(32)) mem_bus ();

  fetch_ctrl #(.XLEN(32), .PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .stall_i      (stall),
    .mem          (mem_bus.master),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .pcplus4_o    (pcplus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    cyc(); cyc();
    n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_bus.req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    n_checks++; if (pcplus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pcplus4: got %h want 4", pcplus4); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] data;
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      data = 32'h1000_0013 + 32'(k);
      n_checks++; if (mem_bus.req !== 1'b1) begin n_fail++; $display("FAIL zw_req k=%0d: got %b want 1", k, mem_bus.req); end
      n_checks++; if (mem_bus.addr !== 32'(4 * k)) begin n_fail++; $display("FAIL zw_addr k=%0d: got %h want %h", k, mem_bus.addr, 32'(4 * k)); end
      mem_bus.gnt = 1'b1;
      cyc();
      mem_bus.gnt = 1'b0;
      n_checks++; if (mem_bus.req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL zw_wait k=%0d: got req=%b valid=%b want 0/0", k, mem_bus.req, inst_valid); end
      mem_bus.rvalid = 1'b1; mem_bus.rdata = data;
      cyc();
      mem_bus.rvalid = 1'b0;
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid k=%0d: got %b want 1", k, inst_valid); end
      n_checks++; if (inst_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL zw_inst_pc k=%0d: got %h want %h", k, inst_pc, 32'(4 * k)); end
      n_checks++; if (inst !== data) begin n_fail++; $display("FAIL zw_inst k=%0d: got %h want %h", k, inst, data); end
      n_checks++; if (pcplus4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL zw_pcplus4 k=%0d: got %h want %h", k, pcplus4, 32'(4 * k + 4)); end
      cyc();
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL zw_pulse k=%0d: got %b want 0", k, inst_valid); end
    end
  endtask

  task automatic test_stall();
    n_checks++; if (mem_bus.addr !== 32'hC) begin n_fail++; $display("FAIL st_addr: got %h want c", mem_bus.addr); end
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0050_0093; stall = 1'b1;
    cyc();
    mem_bus.rvalid = 1'b0; mem_bus.rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'hC) begin n_fail++; $display("FAIL st_hold i=%0d: got valid=%b inst=%h pc=%h want 1/00500093/c", i, inst_valid, inst, inst_pc); end
      n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL st_noreq i=%0d: got %b want 0", i, mem_bus.req); end
      cyc();
    end
    stall = 1'b0;
    n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL st_req_early: got %b want 0", mem_bus.req); end
    cyc();
    n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h10) begin n_fail++; $display("FAIL st_next: got req=%b addr=%h want 1/10", mem_bus.req, mem_bus.addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL st_valid_drop: got %b want 0", inst_valid); end
  endtask

  task automatic test_redirect_wait();
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (inst_valid !== 1'b0 || mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rw_wait i=%0d: got valid=%b req=%b want 0/0", i, inst_valid, mem_bus.req); end
      cyc();
    end
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hDEAD_BEEF;
    cyc();
    mem_bus.rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped i=%0d: got %b want 0", i, inst_valid); end
      n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h100) begin n_fail++; $display("FAIL rw_next i=%0d: got req=%b addr=%h want 1/100", i, mem_bus.req, mem_bus.addr); end
      cyc();
    end
  endtask

  task automatic test_redirect_req();
    // gnt and redirect together: retarget to 0x8, drop that response
    mem_bus.gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h8;
    cyc();
    mem_bus.gnt = 1'b0; redirect = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h1111_1111;
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h8) begin n_fail++; $display("FAIL rr_gnt_redir: got valid=%b req=%b addr=%h want 0/1/8", inst_valid, mem_bus.req, mem_bus.addr); end
    redirect = 1'b1; redirect_pc = 32'h203;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h8) begin n_fail++; $display("FAIL rr_hold_addr i=%0d: got req=%b addr=%h want 1/8", i, mem_bus.req, mem_bus.addr); end
      if (i == 0) cyc();
    end
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h2222_2222;
    n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rr_wait_req: got %b want 0", mem_bus.req); end
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_dropped: got %b want 0", inst_valid); end
    n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h200) begin n_fail++; $display("FAIL rr_next: got req=%b addr=%h want 1/200", mem_bus.req, mem_bus.addr); end
  endtask

  task automatic test_redirect_hold();
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h3333_3333;
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'h3333_3333) begin n_fail++; $display("FAIL rh_held: got valid=%b pc=%h inst=%h want 1/200/33333333", inst_valid, inst_pc, inst); end
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b0;
    cyc();
    redirect = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h40) begin n_fail++; $display("FAIL rh_redir: got valid=%b req=%b addr=%h want 0/1/40", inst_valid, mem_bus.req, mem_bus.addr); end
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h4444_4444;
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || pcplus4 !== 32'h44) begin n_fail++; $display("FAIL rh_fetch: got valid=%b pc=%h pc4=%h want 1/40/44", inst_valid, inst_pc, pcplus4); end
    cyc();
    n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h44) begin n_fail++; $display("FAIL rh_consume: got req=%b addr=%h want 1/44", mem_bus.req, mem_bus.addr); end
  endtask

  task automatic test_reset_mid();
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if (mem_bus.req !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst !== 32'h0) begin n_fail++; $display("FAIL rm_cleared: got req=%b valid=%b pc=%h inst=%h want 0/0/0/0", mem_bus.req, inst_valid, inst_pc, inst); end
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stray i=%0d: got %b want 0", i, inst_valid); end
      n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0) begin n_fail++; $display("FAIL rm_first i=%0d: got req=%b addr=%h want 1/0", i, mem_bus.req, mem_bus.addr); end
    end
    mem_bus.rvalid = 1'b0;
  endtask

  task automatic test_wrap();
    mem_bus.gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    mem_bus.gnt = 1'b0; redirect = 1'b0; mem_bus.rvalid = 1'b1;
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr: got req=%b addr=%h want 1/fffffffc", mem_bus.req, mem_bus.addr); end
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h6666_6666;
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin n_fail++; $display("FAIL wr_inst: got valid=%b pc=%h pc4=%h want 1/fffffffc/0", inst_valid, inst_pc, pcplus4); end
    cyc();
    n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0) begin n_fail++; $display("FAIL wr_next: got req=%b addr=%h want 1/0", mem_bus.req, mem_bus.addr); end
  endtask

  task automatic test_redirect_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    n_checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h80) begin n_fail++; $display("FAIL ri_idle: got req=%b addr=%h want 1/80", mem_bus.req, mem_bus.addr); end
    mem_bus.gnt = 1'b1;
    cyc();
    // redirect in the same cycle as rvalid: data dropped, no lingering discard
    mem_bus.gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h301; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h7777_7777;
    cyc();
    redirect = 1'b0; mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h300) begin n_fail++; $display("FAIL ri_rv_redir: got valid=%b req=%b addr=%h want 0/1/300", inst_valid, mem_bus.req, mem_bus.addr); end
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hCAFE_F00D;
    cyc();
    mem_bus.rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ri_fetch: got valid=%b pc=%h inst=%h want 1/300/cafef00d", inst_valid, inst_pc, inst); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_hold();
    test_reset_mid();
    test_wrap();
    test_redirect_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
